// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: opcodes,
// ALU operation encodings, sequencer states and instruction classes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CL_R,
    CL_I,
    CL_LOAD,
    CL_STORE,
    CL_ILLEGAL
  } class_e;

endpackage

// File: rtl/opcode_classify.sv
// Combinational map from a 7-bit RV32I opcode to its instruction class.
module opcode_classify
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] cls
);

  always_comb begin
    cls = CL_ILLEGAL;
    unique case (opcode)
      OPC_R:     cls = CL_R;
      OPC_I:     cls = CL_I;
      OPC_LOAD:  cls = CL_LOAD;
      OPC_STORE: cls = CL_STORE;
      default:   cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I sequencer sharing one memory port between fetch and
// load/store; also counts retired instructions and traps on bad opcodes.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt,
  input  logic [6:0]          instr_opcode,
  input  logic                mem_ready,
  output logic                pc_write_en,
  output logic                ir_write_en,
  output logic                mem_addr_sel,
  output logic                mem_read_en,
  output logic                mem_write_en,
  output logic                alu_src,
  output logic [1:0]          alu_op,
  output logic                reg_write_en,
  output logic                mem_to_reg_en,
  output logic                illegal_instr,
  output logic [RETIRE_W-1:0] retire_count
);

  state_e              state_q, state_d;
  class_e              cls_q, cls_d;
  logic                req_q, req_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;
  logic [2:0]          dec_cls;
  logic                issue;
  logic                retire;

  opcode_classify u_classify (
    .opcode (instr_opcode),
    .cls    (dec_cls)
  );

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    req_d         = req_q;
    retire        = 1'b0;
    pc_write_en   = 1'b0;
    ir_write_en   = 1'b0;
    mem_addr_sel  = 1'b0;
    mem_read_en   = 1'b0;
    mem_write_en  = 1'b0;
    alu_src       = 1'b0;
    alu_op        = ALUOP_ADD;
    reg_write_en  = 1'b0;
    mem_to_reg_en = 1'b0;
    illegal_instr = 1'b0;
    // halt only gates the start of a fetch; a request once issued is held
    issue         = !halt || req_q;

    unique case (state_q)
      ST_FETCH: begin
        if (issue) begin
          mem_read_en = 1'b1;
          if (mem_ready) begin
            ir_write_en = 1'b1;
            pc_write_en = 1'b1;
            req_d       = 1'b0;
            state_d     = ST_DECODE;
          end else begin
            req_d = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        cls_d   = class_e'(dec_cls);
        state_d = (class_e'(dec_cls) == CL_ILLEGAL) ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        unique case (cls_q)
          CL_R: begin
            alu_op  = ALUOP_FUNCT;
            state_d = ST_WB;
          end
          CL_I: begin
            alu_op  = ALUOP_FUNCT;
            alu_src = 1'b1;
            state_d = ST_WB;
          end
          CL_LOAD, CL_STORE: begin
            alu_src = 1'b1;
            state_d = ST_MEM;
          end
          default: state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        mem_addr_sel = 1'b1;
        alu_src      = 1'b1;
        if (cls_q == CL_LOAD) begin
          mem_read_en = 1'b1;
          if (mem_ready) state_d = ST_WB;
        end else begin
          mem_write_en = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        reg_write_en  = 1'b1;
        mem_to_reg_en = (cls_q == CL_LOAD);
        retire        = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_TRAP: illegal_instr = 1'b1;
      default: state_d = ST_FETCH;
    endcase

    retire_d = retire ? retire_q + RETIRE_W'(1) : retire_q;

    // Reset forces every output quiet no matter what state is held
    if (reset) begin
      pc_write_en   = 1'b0;
      ir_write_en   = 1'b0;
      mem_addr_sel  = 1'b0;
      mem_read_en   = 1'b0;
      mem_write_en  = 1'b0;
      alu_src       = 1'b0;
      alu_op        = ALUOP_ADD;
      reg_write_en  = 1'b0;
      mem_to_reg_en = 1'b0;
      illegal_instr = 1'b0;
    end
    retire_count = reset ? '0 : retire_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      cls_q    <= CL_ILLEGAL;
      req_q    <= 1'b0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      req_q    <= req_d;
      retire_q <= retire_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: a per-cycle vector table followed by
// hand-written halt/reset corner sequences and a retire-counter wrap run.
module tb_multicycle_ctrl_fsm;

  localparam int RW = 3;

  // {pc_we, ir_we, addr_sel, rd, wr, alu_src, alu_op[1:0], reg_we, m2r, illegal}
  localparam logic [10:0] X_IDLE   = 11'b000_0000_0000;
  localparam logic [10:0] X_FISSUE = 11'b000_1000_0000;
  localparam logic [10:0] X_FDONE  = 11'b110_1000_0000;
  localparam logic [10:0] X_EXR    = 11'b000_0001_0000;
  localparam logic [10:0] X_EXI    = 11'b000_0011_0000;
  localparam logic [10:0] X_EXLS   = 11'b000_0010_0000;
  localparam logic [10:0] X_MEMLD  = 11'b001_1010_0000;
  localparam logic [10:0] X_MEMST  = 11'b001_0110_0000;
  localparam logic [10:0] X_WBR    = 11'b000_0000_0100;
  localparam logic [10:0] X_WBLD   = 11'b000_0000_0110;
  localparam logic [10:0] X_TRAP   = 11'b000_0000_0001;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          halt = 1'b0;
  logic [6:0]    instr_opcode = 7'd0;
  logic          mem_ready = 1'b1;
  logic          pc_write_en, ir_write_en, mem_addr_sel, mem_read_en, mem_write_en;
  logic          alu_src, reg_write_en, mem_to_reg_en, illegal_instr;
  logic [1:0]    alu_op;
  logic [RW-1:0] retire_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rst;
    logic        hlt;
    logic [6:0]  op;
    logic        rdy;
    logic [10:0] exp;
    logic [7:0]  ret;
  } vec_t;

  vec_t tbl[$];

  multicycle_ctrl_fsm #(.RETIRE_W(RW)) dut (
    .clk           (clk),
    .reset         (reset),
    .halt          (halt),
    .instr_opcode  (instr_opcode),
    .mem_ready     (mem_ready),
    .pc_write_en   (pc_write_en),
    .ir_write_en   (ir_write_en),
    .mem_addr_sel  (mem_addr_sel),
    .mem_read_en   (mem_read_en),
    .mem_write_en  (mem_write_en),
    .alu_src       (alu_src),
    .alu_op        (alu_op),
    .reg_write_en  (reg_write_en),
    .mem_to_reg_en (mem_to_reg_en),
    .illegal_instr (illegal_instr),
    .retire_count  (retire_count)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic h, input logic [6:0] o,
                     input logic y, input logic [10:0] e, input int n);
    tbl.push_back('{r, h, o, y, e, 8'(n)});
  endtask

  // Drive one cycle's inputs after the falling edge, check outputs 1 time unit later
  task automatic step(input string nm, input logic r, input logic h, input logic [6:0] o,
                      input logic y, input logic [10:0] e, input int n);
    logic [10:0]   got;
    logic [RW-1:0] exp_ret;
    @(negedge clk);
    reset = r; halt = h; instr_opcode = o; mem_ready = y;
    #1;
    got = {pc_write_en, ir_write_en, mem_addr_sel, mem_read_en, mem_write_en,
           alu_src, alu_op, reg_write_en, mem_to_reg_en, illegal_instr};
    exp_ret = RW'(n);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s outputs: got %b expected %b", nm, got, e);
    end
    checks++;
    if (retire_count !== exp_ret) begin
      errors++;
      $display("FAIL %s retire_count: got %0d expected %0d", nm, retire_count, exp_ret);
    end
    checks++;
    if (mem_read_en && mem_write_en) begin
      errors++;
      $display("FAIL %s rd_wr_exclusive: got rd=1 wr=1 expected not both", nm);
    end
  endtask

  initial begin
    // reset held 3 cycles with mem_ready high
    for (int i = 0; i < 3; i++) add(1, 0, OP_R, 1, X_IDLE, 0);
    add(0, 0, OP_R, 1, X_FDONE, 0);
    // R-type, zero wait
    add(0, 0, OP_R, 1, X_IDLE, 0);
    add(0, 0, OP_R, 1, X_EXR, 0);
    add(0, 0, OP_R, 1, X_WBR, 0);
    // LOAD with two MEM wait states; opcode changes after DECODE
    add(0, 0, OP_LD, 1, X_FDONE, 1);
    add(0, 0, OP_LD, 1, X_IDLE, 1);
    add(0, 0, OP_R, 1, X_EXLS, 1);
    add(0, 0, OP_R, 0, X_MEMLD, 1);
    add(0, 0, OP_R, 0, X_MEMLD, 1);
    add(0, 0, OP_R, 1, X_MEMLD, 1);
    add(0, 0, OP_R, 1, X_WBLD, 1);
    // STORE, zero wait
    add(0, 0, OP_ST, 1, X_FDONE, 2);
    add(0, 0, OP_ST, 1, X_IDLE, 2);
    add(0, 0, OP_ST, 1, X_EXLS, 2);
    add(0, 0, OP_ST, 1, X_MEMST, 2);
    // I-type with one fetch wait state
    add(0, 0, OP_I, 0, X_FISSUE, 3);
    add(0, 0, OP_I, 1, X_FDONE, 3);
    add(0, 0, OP_I, 1, X_IDLE, 3);
    add(0, 0, OP_I, 1, X_EXI, 3);
    add(0, 0, OP_I, 1, X_WBR, 3);
    // illegal opcode traps
    add(0, 0, OP_BAD, 1, X_FDONE, 4);
    add(0, 0, OP_BAD, 1, X_IDLE, 4);
    for (int i = 0; i < 10; i++) add(0, 0, OP_R, 1'(i), X_TRAP, 4);
    add(1, 0, OP_R, 1, X_IDLE, 0);
    add(0, 0, OP_R, 0, X_FISSUE, 0);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].hlt, tbl[i].op, tbl[i].rdy,
           tbl[i].exp, int'(tbl[i].ret));

    // halt raised while a fetch is outstanding: request held until ready
    step("halt_hold0", 0, 1, OP_R, 0, X_FISSUE, 0);
    step("halt_hold1", 0, 1, OP_R, 0, X_FISSUE, 0);
    step("halt_done",  0, 1, OP_R, 1, X_FDONE, 0);
    step("halt_dec",   0, 1, OP_R, 1, X_IDLE, 0);
    step("halt_exec",  0, 1, OP_R, 1, X_EXR, 0);
    step("halt_wb",    0, 1, OP_R, 1, X_WBR, 0);
    // halt high at FETCH entry: no request even with mem_ready high
    for (int i = 0; i < 5; i++)
      step($sformatf("halt_idle%0d", i), 0, 1, OP_R, 1, X_IDLE, 1);
    step("halt_rel",   0, 0, OP_LD, 0, X_FISSUE, 1);
    step("halt_late",  0, 1, OP_LD, 0, X_FISSUE, 1);
    step("halt_ldone", 0, 1, OP_LD, 1, X_FDONE, 1);
    step("ld_dec",     0, 0, OP_LD, 1, X_IDLE, 1);
    step("ld_exec",    0, 0, OP_LD, 1, X_EXLS, 1);
    step("ld_mem",     0, 0, OP_LD, 0, X_MEMLD, 1);
    // reset in the middle of a LOAD's MEM phase
    step("mid_rst0",   1, 0, OP_LD, 1, X_IDLE, 0);
    step("mid_rst1",   1, 0, OP_LD, 1, X_IDLE, 0);
    step("post_rst",   0, 0, OP_R, 0, X_FISSUE, 0);

    // retire counter wraps modulo 2^RW
    for (int k = 0; k < 9; k++) begin
      step($sformatf("wrap_f%0d", k), 0, 0, OP_R, 1, X_FDONE, k);
      step($sformatf("wrap_d%0d", k), 0, 0, OP_R, 1, X_IDLE, k);
      step($sformatf("wrap_e%0d", k), 0, 0, OP_R, 1, X_EXR, k);
      step($sformatf("wrap_w%0d", k), 0, 0, OP_R, 1, X_WBR, k);
    end
    step("wrap_end", 0, 0, OP_R, 0, X_FISSUE, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish within 20000");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Multi-cycle sequencer for the RV32I datapath. It replaces single-cycle opcode decode with a FETCH/DECODE/EXEC/MEM/WB state machine that shares one memory port between instruction fetch and load/store. It drives the same datapath enables as single-cycle control (alu_op, alu_src, reg/mem enables) plus the PC/IR write strobes and the memory address select. It also counts retired instructions and traps on unsupported opcodes.

## Interface
- `RETIRE_W`, default 32: retired-instruction counter width.
- `clk` input 1: sole clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `halt` input 1: when high, no new fetch is issued; an outstanding request still completes.
- `instr_opcode` input 7: IR[6:0]; valid from DECODE onward.
- `mem_ready` input 1: memory completes the current request this cycle.
- `pc_write_en` output 1: PC <= PC+4.
- `ir_write_en` output 1: IR <= memory read data.
- `mem_addr_sel` output 1: 0 = PC, 1 = ALU result.
- `mem_read_en` output 1: read request.
- `mem_write_en` output 1: write request.
- `alu_src` output 1: 0 = rs2, 1 = immediate.
- `alu_op` output 2: 00 = add (address), 10 = funct-decoded.
- `reg_write_en` output 1: register file write.
- `mem_to_reg_en` output 1: writeback source is memory data.
- `illegal_instr` output 1: sticky trap flag.
- `retire_count` output RETIRE_W: instructions completed since reset.

## Operation
- Opcode classes: R = 0110011, I = 0010011, LOAD = 0000011, STORE = 0100011. Any other opcode is ILLEGAL.
- The class is latched in DECODE. Later states use the latched class, not `instr_opcode`.
- FETCH:
  - If halt is low, or a request is already outstanding: mem_read_en=1, mem_addr_sel=0.
  - Once asserted, the request is held until mem_ready, regardless of halt.
  - On mem_ready: ir_write_en=1 and pc_write_en=1 in that same cycle, then go to DECODE.
- DECODE: all enables 0. R/I/LOAD/STORE go to EXEC; ILLEGAL goes to TRAP.
- EXEC:
  - R: alu_op=10, alu_src=0, go to WB.
  - I: alu_op=10, alu_src=1, go to WB.
  - LOAD/STORE: alu_op=00, alu_src=1, go to MEM.
- MEM: mem_addr_sel=1, alu_op=00, alu_src=1.
  - LOAD: mem_read_en=1; on mem_ready, go to WB.
  - STORE: mem_write_en=1; on mem_ready, retire and go to FETCH.
- WB: reg_write_en=1; mem_to_reg_en=1 only for LOAD. Retire, then go to FETCH.
- TRAP: illegal_instr=1. No memory requests or writes. Only reset exits.
- Retire: retire_count += 1, wrapping modulo 2^RETIRE_W.
- mem_read_en and mem_write_en are never high together.
- reg_write_en is high only in WB.

## Timing
- Datapath enables are decoded from state and latched class only.
- Exceptions: ir_write_en, pc_write_en and the MEM-exit transition also depend on mem_ready, as a single-cycle pulse in the mem_ready cycle.
- Zero-wait memory (mem_ready high in the cycle of the request):
  - R/I: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - Each wait cycle adds 1.
- Reset:
  - While reset is high, every output is 0 and retire_count=0, regardless of state.
  - The state register becomes FETCH with no request outstanding.
  - The first request appears in the first cycle reset is low.
- Reset during FETCH or MEM drops the outstanding request. Memory must tolerate an abandoned request.
- halt rising in the same cycle as FETCH entry suppresses the fetch. halt rising after the request is issued does not.
- mem_ready outside FETCH/MEM, or while halted with no request, is ignored.

## Structure
- Shared package `riscv_ctrl_pkg`:
  - Opcode constants.
  - alu_op encodings (ALUOP_ADD=2'b00, ALUOP_FUNCT=2'b10).
  - State enum ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP.
  - Class enum CL_R, CL_I, CL_LOAD, CL_STORE, CL_ILLEGAL.
- Sub-module `opcode_classify`: combinational opcode-to-class map, shared with future decoders.
- The FSM, request-outstanding flag, class register and retire counter live in `multicycle_ctrl_fsm`.

## Test plan
- Reset held 3 cycles with mem_ready=1 → all outputs 0 and retire_count=0. In the cycle after release: mem_read_en=1, mem_addr_sel=0.
- R-type 0110011, zero-wait → FETCH, DECODE, EXEC, WB in 4 cycles. alu_op=10 and alu_src=0 in EXEC; reg_write_en=1 only in WB; retire_count=1.
- LOAD 0000011 with 2 wait states in MEM → mem_read_en with mem_addr_sel=1 held 3 cycles. WB has reg_write_en=1 and mem_to_reg_en=1. Total 7 cycles.
- STORE 0100011, zero-wait → mem_write_en=1 in MEM with alu_op=00, alu_src=1. reg_write_en never high. Returns to FETCH; retire_count increments.
- Opcode 1111111 → TRAP. illegal_instr=1; no mem_read_en/mem_write_en for 10 cycles; retire_count unchanged. A reset pulse then clears the trap and fetch resumes.
- halt and reset edge cases:
  - halt=1 at FETCH entry → no request for 5 cycles.
  - halt raised with a fetch outstanding and mem_ready low → request held until mem_ready.
  - reset asserted mid-MEM LOAD → all outputs 0 in the next cycle.
